// File: rtl/fifo_drain_packer_if.sv
// FIFO read-port and packed output stream of fifo_drain_packer.
// The master modport is the packer's side; slave is the FIFO/downstream side.
interface fifo_drain_packer_if #(
  parameter int DATA_WIDTH = 6,
  parameter int PACK       = 4,
  parameter int CNT_W      = $clog2(PACK + 1)
);
  logic                       fifo_empty;
  logic                       fifo_rd_en;
  logic [DATA_WIDTH-1:0]      fifo_data;
  logic                       m_valid;
  logic                       m_ready;
  logic [PACK*DATA_WIDTH-1:0] m_data;
  logic [CNT_W-1:0]           m_cnt;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data, m_cnt
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_cnt
  );
endinterface

// File: rtl/fifo_drain_packer.sv
// Drains a 1-cycle-latency FIFO, packs PACK words per output beat, and
// emits a partial beat (with word count) on a flush request.
module fifo_drain_packer #(
  parameter int DATA_WIDTH = 6,
  parameter int PACK       = 4,
  parameter int CNT_W      = $clog2(PACK + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  fifo_drain_packer_if.master  bus
);
  localparam int IDX_W = $clog2(PACK);
  localparam logic [CNT_W-1:0] PACK_C  = CNT_W'(PACK);
  localparam logic [CNT_W-1:0] PACK_M1 = CNT_W'(PACK - 1);

  logic [PACK-1:0][DATA_WIDTH-1:0] acc;
  logic [PACK-1:0][DATA_WIDTH-1:0] part_word;
  logic [CNT_W-1:0]                acc_cnt;
  logic                            rd_pend;
  logic                            flush_pend;
  logic                            m_valid_r;
  logic [PACK*DATA_WIDTH-1:0]      m_data_r;
  logic [CNT_W-1:0]                m_cnt_r;
  logic                            out_free;
  logic                            rd_en;
  logic [CNT_W:0]                  credit;
  logic [IDX_W-1:0]                wr_idx;

  always_comb begin
    out_free = !m_valid_r || bus.m_ready;
    credit   = {1'b0, acc_cnt} + {{CNT_W{1'b0}}, rd_pend};
    // Look-ahead read: the group-completing word can go straight to an empty output register.
    rd_en    = rst_n && !bus.fifo_empty && !flush_pend &&
               ((credit < {1'b0, PACK_C}) ||
                ((credit == {1'b0, PACK_C}) && (acc_cnt < PACK_C) && !m_valid_r));
    wr_idx   = acc_cnt[IDX_W-1:0];
    part_word = '0;
    for (int unsigned i = 0; i < PACK; i++) begin
      if (i < 32'(acc_cnt)) part_word[i] = acc[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      acc_cnt    <= '0;
      rd_pend    <= 1'b0;
      flush_pend <= 1'b0;
      m_valid_r  <= 1'b0;
      m_data_r   <= '0;
      m_cnt_r    <= '0;
    end else begin
      rd_pend <= rd_en;
      if (m_valid_r && bus.m_ready) m_valid_r <= 1'b0;
      if (!flush_pend && flush) flush_pend <= 1'b1;

      if (rd_pend) begin
        if ((acc_cnt == PACK_M1) && out_free) begin
          m_data_r  <= {bus.fifo_data, acc[PACK-2:0]};
          m_cnt_r   <= PACK_C;
          m_valid_r <= 1'b1;
          acc_cnt   <= '0;
        end else begin
          acc[wr_idx] <= bus.fifo_data;
          acc_cnt     <= acc_cnt + CNT_W'(1);
        end
      end else if (acc_cnt == PACK_C) begin
        if (out_free) begin
          m_data_r  <= acc;
          m_cnt_r   <= PACK_C;
          m_valid_r <= 1'b1;
          acc_cnt   <= '0;
        end
      end else if (flush_pend) begin
        if (acc_cnt == '0) begin
          flush_pend <= 1'b0;
        end else if (out_free) begin
          m_data_r   <= part_word;
          m_cnt_r    <= acc_cnt;
          m_valid_r  <= 1'b1;
          acc_cnt    <= '0;
          flush_pend <= 1'b0;
        end
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid_r;
  assign bus.m_data     = m_data_r;
  assign bus.m_cnt      = m_cnt_r;
endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed bench for fifo_drain_packer with a behavioural 1-cycle-latency FIFO.
module tb_fifo_drain_packer;
  logic clk;
  logic rst_n;
  logic fifo_rst_n;
  logic flush;
  int   tests;
  int   fails;
  int   base;

  logic [5:0]  mem [0:63];
  int          wr_ptr;
  int          rd_ptr;
  logic [5:0]  fifo_q;
  logic [23:0] out_d[$];
  logic [2:0]  out_c[$];

  fifo_drain_packer_if #(.DATA_WIDTH(6), .PACK(4)) bus ();

  fifo_drain_packer #(.DATA_WIDTH(6), .PACK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  assign bus.fifo_data  = fifo_q;

  always @(posedge clk) begin
    if (!fifo_rst_n) begin
      rd_ptr <= wr_ptr;
      fifo_q <= '0;
    end else if (bus.fifo_rd_en) begin
      fifo_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      out_d.push_back(bus.m_data);
      out_c.push_back(bus.m_cnt);
    end
  end

  always @(negedge clk) begin
    tests++;
    assert (!(bus.fifo_rd_en && bus.fifo_empty)) else begin
      fails++;
      $error("FAIL rd_on_empty: got rd_en=%0b with empty=%0b, required no read", bus.fifo_rd_en, bus.fifo_empty);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    tests = 0; fails = 0;
    wr_ptr = 0; rd_ptr = 0;
    rst_n = 1'b0; fifo_rst_n = 1'b1; flush = 1'b0; bus.m_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Full-rate drain of two groups
    for (int v = 1; v <= 8; v++) push(6'(v));
    #1;
    check("rst_m_valid", 32'(bus.m_valid), 32'h0);
    check("rst_m_cnt", 32'(bus.m_cnt), 32'h0);
    check("rst_m_data", 32'(bus.m_data), 32'h0);
    check("rst_rd_en_low", 32'(bus.fifo_rd_en), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    base = rd_ptr;
    for (int i = 0; i < 8; i++) begin
      #1 check("burst_rd_en", 32'(bus.fifo_rd_en), 32'h1);
      @(negedge clk);
    end
    #1;
    check("burst_rd_stop", 32'(bus.fifo_rd_en), 32'h0);
    check("burst_rd_count", 32'(rd_ptr - base), 32'd8);
    repeat (4) @(negedge clk);
    check("burst_out_n", 32'(out_d.size()), 32'd2);
    check("burst_d0", 32'(out_d[0]), 32'h103081);
    check("burst_c0", 32'(out_c[0]), 32'd4);
    check("burst_d1", 32'(out_d[1]), 32'h207185);
    check("burst_c1", 32'(out_c[1]), 32'd4);
    check("burst_idle", 32'(bus.m_valid), 32'h0);

    // Backpressure: output and accumulator both fill, reads stop at 8
    rst_n = 1'b0; bus.m_ready = 1'b0;
    out_d.delete(); out_c.delete();
    @(negedge clk);
    for (int v = 1; v <= 8; v++) push(6'(v));
    @(negedge clk);
    rst_n = 1'b1;
    base = rd_ptr;
    repeat (10) @(negedge clk);
    check("stall_valid_early", 32'(bus.m_valid), 32'h1);
    check("stall_data_early", 32'(bus.m_data), 32'h103081);
    repeat (10) @(negedge clk);
    check("stall_rd_count", 32'(rd_ptr - base), 32'd8);
    check("stall_rd_en", 32'(bus.fifo_rd_en), 32'h0);
    check("stall_acc_cnt", 32'(dut.acc_cnt), 32'd4);
    check("stall_valid", 32'(bus.m_valid), 32'h1);
    check("stall_data", 32'(bus.m_data), 32'h103081);
    check("stall_cnt", 32'(bus.m_cnt), 32'd4);
    bus.m_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("stall_out_n", 32'(out_d.size()), 32'd2);
    check("stall_d0", 32'(out_d[0]), 32'h103081);
    check("stall_d1", 32'(out_d[1]), 32'h207185);
    check("stall_c1", 32'(out_c[1]), 32'd4);
    check("stall_idle", 32'(bus.m_valid), 32'h0);

    // Flush of a 3-word partial group
    out_d.delete(); out_c.delete();
    push(6'h2A); push(6'h15); push(6'h3F);
    repeat (6) @(negedge clk);
    check("part_acc_cnt", 32'(dut.acc_cnt), 32'd3);
    check("part_no_out", 32'(bus.m_valid), 32'h0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("part_out_n", 32'(out_d.size()), 32'd1);
    check("part_cnt", 32'(out_c[0]), 32'd3);
    check("part_data", 32'(out_d[0]), 32'h03F56A);
    check("part_flush_clr", 32'(dut.flush_pend), 32'h0);

    // Flush with nothing accumulated
    out_d.delete(); out_c.delete();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("empty_flush_pend", 32'(dut.flush_pend), 32'h1);
    check("empty_flush_novalid", 32'(bus.m_valid), 32'h0);
    @(negedge clk);
    check("empty_flush_clr", 32'(dut.flush_pend), 32'h0);
    check("empty_flush_novalid2", 32'(bus.m_valid), 32'h0);
    repeat (2) @(negedge clk);
    check("empty_flush_no_out", 32'(out_d.size()), 32'd0);

    // Flush coinciding with a read issue waits for the arrival
    push(6'h11); push(6'h22);
    repeat (5) @(negedge clk);
    check("race_pre_acc", 32'(dut.acc_cnt), 32'd2);
    out_d.delete(); out_c.delete();
    push(6'h33); push(6'h0A);
    flush = 1'b1;
    base = rd_ptr;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("race_rd_pend", 32'(dut.rd_pend), 32'h1);
    check("race_flush_pend", 32'(dut.flush_pend), 32'h1);
    check("race_blocks_rd", 32'(bus.fifo_rd_en), 32'h0);
    check("race_one_read", 32'(rd_ptr - base), 32'd1);
    @(negedge clk);
    check("race_acc_cnt", 32'(dut.acc_cnt), 32'd3);
    check("race_still_blocked", 32'(bus.fifo_rd_en), 32'h0);
    @(negedge clk);
    check("race_valid", 32'(bus.m_valid), 32'h1);
    check("race_cnt", 32'(bus.m_cnt), 32'd3);
    check("race_data", 32'(bus.m_data), 32'h033891);
    repeat (3) @(negedge clk);
    check("race_out_n", 32'(out_d.size()), 32'd1);
    check("race_resume_acc", 32'(dut.acc_cnt), 32'd1);

    // Reset with a read in flight and a held output word
    bus.m_ready = 1'b0;
    for (int v = 1; v <= 5; v++) push(6'(v));
    repeat (4) @(negedge clk);
    check("mid_pre_rd_pend", 32'(dut.rd_pend), 32'h1);
    check("mid_pre_valid", 32'(bus.m_valid), 32'h1);
    check("mid_pre_data", 32'(bus.m_data), 32'h0C204A);
    rst_n = 1'b0; fifo_rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.m_valid), 32'h0);
    check("mid_rst_cnt", 32'(bus.m_cnt), 32'h0);
    check("mid_rst_data", 32'(bus.m_data), 32'h0);
    check("mid_rst_acc", 32'(dut.acc_cnt), 32'h0);
    check("mid_rst_rd_pend", 32'(dut.rd_pend), 32'h0);
    check("mid_rst_rd_en", 32'(bus.fifo_rd_en), 32'h0);
    out_d.delete(); out_c.delete();
    rst_n = 1'b1; fifo_rst_n = 1'b1; bus.m_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_no_out", 32'(out_d.size()), 32'd0);
    check("mid_idle", 32'(bus.m_valid), 32'h0);
    check("mid_acc_idle", 32'(dut.acc_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
